// File: rtl/apb_regfile_slave.sv
// APB completer with NUM_REGS word registers, programmable wait states and PSLVERR.
// Read-only slots return live ro_in values; committed writes raise a one-cycle wr_pulse.
module apb_regfile_slave #(
   parameter int unsigned          ADDR_WIDTH  = 8,
   parameter int unsigned          DATA_WIDTH  = 32,
   parameter int unsigned          NUM_REGS    = 16,
   parameter int unsigned          WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0]  RO_MASK     = '0
) (
   input  logic                           PCLK,
   input  logic                           PRESETn,
   input  logic                           PSEL,
   input  logic                           PENABLE,
   input  logic [ADDR_WIDTH-1:0]          PADDR,
   input  logic                           PWRITE,
   input  logic [DATA_WIDTH-1:0]          PWDATA,
   output logic [DATA_WIDTH-1:0]          PRDATA,
   output logic                           PREADY,
   output logic                           PSLVERR,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
   output logic [NUM_REGS-1:0]            wr_pulse
);

   localparam int unsigned IW = ADDR_WIDTH - 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_READY
   } state_t;

   state_t                state;
   logic [3:0]            cnt;
   logic [IW-1:0]         idx_q;
   logic                  write_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  err_q;

   logic                  setup_in_range;
   logic                  setup_ro;
   logic                  setup_err;
   logic [DATA_WIDTH-1:0] setup_rdata;

   // Index decode is done by comparison so out-of-range addresses never index past NUM_REGS.
   always_comb begin
      setup_in_range = 1'b0;
      setup_ro       = 1'b0;
      setup_rdata    = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (32'(PADDR[ADDR_WIDTH-1:2]) == i) begin
            setup_in_range = 1'b1;
            setup_ro       = RO_MASK[i];
            setup_rdata    = RO_MASK[i] ? ro_in[i*DATA_WIDTH +: DATA_WIDTH]
                                        : reg_out[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      setup_err = (PADDR[1:0] != 2'b00) | ~setup_in_range | (PWRITE & setup_ro);
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state    <= S_IDLE;
         cnt      <= '0;
         idx_q    <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         PRDATA   <= '0;
         PREADY   <= 1'b0;
         PSLVERR  <= 1'b0;
         reg_out  <= '0;
         wr_pulse <= '0;
      end else begin
         wr_pulse <= '0;
         case (state)
            S_IDLE: begin
               if (PSEL && !PENABLE) begin
                  idx_q   <= PADDR[ADDR_WIDTH-1:2];
                  write_q <= PWRITE;
                  wdata_q <= PWDATA;
                  err_q   <= setup_err;
                  PRDATA  <= (!PWRITE && !setup_err) ? setup_rdata : '0;
                  if (WAIT_STATES == 0) begin
                     state   <= S_READY;
                     PREADY  <= 1'b1;
                     PSLVERR <= setup_err;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= 4'(WAIT_STATES - 1);
                  end
               end
            end
            S_WAIT: begin
               if (!PSEL) begin
                  state <= S_IDLE;
               end else if (cnt == 4'd0) begin
                  state   <= S_READY;
                  PREADY  <= 1'b1;
                  PSLVERR <= err_q;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_READY: begin
               if (!PSEL || PENABLE) begin
                  state   <= S_IDLE;
                  PREADY  <= 1'b0;
                  PSLVERR <= 1'b0;
                  if (PSEL && write_q && !err_q) begin
                     for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (32'(idx_q) == i) begin
                           reg_out[i*DATA_WIDTH +: DATA_WIDTH] <= wdata_q;
                           wr_pulse[i]                         <= 1'b1;
                        end
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboarded bench for apb_regfile_slave: three instances (0, 2 and 3 wait states)
// share one APB bus; stimulus queues expected responses, a negedge monitor checks them.
module tb_apb_regfile_slave;

   logic         PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   logic         rstn_ab, rstn_c;
   logic         psel, penable, pwrite;
   logic [7:0]   paddr;
   logic [31:0]  pwdata;
   logic [511:0] ro_in;
   int           sel;

   logic [31:0]  prdata_d  [3];
   logic         pready_d  [3];
   logic         pslverr_d [3];
   logic [511:0] reg_out_d [3];
   logic [15:0]  wr_pulse_d[3];

   logic [31:0]  prdata_m;
   logic         pready_m, pslverr_m, rstn_m;
   logic [511:0] reg_out_m;
   logic [15:0]  wr_pulse_m;

   apb_regfile_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16),
                       .WAIT_STATES(0), .RO_MASK(16'h0000)) u_dut_a (
      .PCLK(PCLK), .PRESETn(rstn_ab), .PSEL(psel && sel == 0), .PENABLE(penable),
      .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata_d[0]),
      .PREADY(pready_d[0]), .PSLVERR(pslverr_d[0]), .reg_out(reg_out_d[0]),
      .ro_in(ro_in), .wr_pulse(wr_pulse_d[0]));

   apb_regfile_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16),
                       .WAIT_STATES(2), .RO_MASK(16'h0001)) u_dut_b (
      .PCLK(PCLK), .PRESETn(rstn_ab), .PSEL(psel && sel == 1), .PENABLE(penable),
      .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata_d[1]),
      .PREADY(pready_d[1]), .PSLVERR(pslverr_d[1]), .reg_out(reg_out_d[1]),
      .ro_in(ro_in), .wr_pulse(wr_pulse_d[1]));

   apb_regfile_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16),
                       .WAIT_STATES(3), .RO_MASK(16'h0000)) u_dut_c (
      .PCLK(PCLK), .PRESETn(rstn_c), .PSEL(psel && sel == 2), .PENABLE(penable),
      .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata_d[2]),
      .PREADY(pready_d[2]), .PSLVERR(pslverr_d[2]), .reg_out(reg_out_d[2]),
      .ro_in(ro_in), .wr_pulse(wr_pulse_d[2]));

   always_comb begin
      prdata_m   = prdata_d[0];
      pready_m   = pready_d[0];
      pslverr_m  = pslverr_d[0];
      reg_out_m  = reg_out_d[0];
      wr_pulse_m = wr_pulse_d[0];
      rstn_m     = rstn_ab;
      if (sel == 1) begin
         prdata_m   = prdata_d[1];
         pready_m   = pready_d[1];
         pslverr_m  = pslverr_d[1];
         reg_out_m  = reg_out_d[1];
         wr_pulse_m = wr_pulse_d[1];
      end else if (sel == 2) begin
         prdata_m   = prdata_d[2];
         pready_m   = pready_d[2];
         pslverr_m  = pslverr_d[2];
         reg_out_m  = reg_out_d[2];
         wr_pulse_m = wr_pulse_d[2];
         rstn_m     = rstn_c;
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic [15:0] pulse;
      int          waits;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic int ws_of(input int s);
      return (s == 0) ? 0 : (s == 1) ? 2 : 3;
   endfunction

   // Monitor: PRDATA stability, PSLVERR gating, wait count, response and next-cycle pulse.
   int          mon_waits = 0;
   logic [15:0] pend_pulse = '0;
   always @(negedge PCLK) begin
      exp_t e;
      if (!rstn_m) begin
         mon_waits  = 0;
         pend_pulse = '0;
      end else begin
         check("wr_pulse", wr_pulse_m, pend_pulse);
         pend_pulse = '0;
         if (psel && penable) begin
            if (q.size() > 0) check("prdata", prdata_m, q[0].rdata);
            if (!pready_m) begin
               check("pslverr_while_wait", pslverr_m, 0);
               mon_waits++;
            end else if (q.size() == 0) begin
               check("unexpected_ready", pready_m, 0);
               mon_waits = 0;
            end else begin
               e = q.pop_front();
               check("pslverr", pslverr_m, e.err);
               check("wait_cycles", mon_waits, e.waits);
               pend_pulse = e.pulse;
               mon_waits  = 0;
            end
         end else begin
            mon_waits = 0;
         end
      end
   end

   task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic ee, input logic [15:0] ep);
      exp_t e;
      int   n;
      e.rdata = er;
      e.err   = ee;
      e.pulse = ep;
      e.waits = ws_of(sel);
      q.push_back(e);
      psel    = 1'b1;
      penable = 1'b0;
      paddr   = a;
      pwrite  = wr;
      pwdata  = d;
      @(posedge PCLK); #1;
      penable = 1'b1;
      n = 0;
      do begin
         @(negedge PCLK);
         n++;
      end while (!pready_m && n < 40);
      if (!pready_m) check("transfer_timeout", pready_m, 1);
      @(posedge PCLK); #1;
      psel    = 1'b0;
      penable = 1'b0;
   endtask

   task automatic idle(input int n);
      psel    = 1'b0;
      penable = 1'b0;
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   function automatic logic [31:0] vec(input int i);
      return {8'hA5, 8'(i), 8'h5A, ~8'(i)};
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
      $fatal(1);
   end

   initial begin
      logic [511:0] exp_regs;
      rstn_ab = 1'b0;
      rstn_c  = 1'b0;
      sel     = 0;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      ro_in   = '0;
      ro_in[31:0] = 32'hCAFE0001;
      repeat (3) @(posedge PCLK);
      #1;
      for (int k = 0; k < 3; k++) begin
         check("rst_pready",   pready_d[k],   0);
         check("rst_pslverr",  pslverr_d[k],  0);
         check("rst_prdata",   prdata_d[k],   0);
         check("rst_reg_out",  reg_out_d[k],  0);
         check("rst_wr_pulse", wr_pulse_d[k], 0);
      end
      rstn_ab = 1'b1;
      rstn_c  = 1'b1;
      idle(1);

      // Zero wait states: basic write/read, then error cases.
      apb(1'b1, 8'h04, 32'hDEADBEEF, 32'h0, 1'b0, 16'h0002);
      apb(1'b0, 8'h04, 32'h0, 32'hDEADBEEF, 1'b0, 16'h0000);
      idle(1);
      exp_regs = '0;
      exp_regs[63:32] = 32'hDEADBEEF;
      check("a_reg_out_after_write", reg_out_m, exp_regs);
      apb(1'b1, 8'h40, 32'h11111111, 32'h0, 1'b1, 16'h0000);
      apb(1'b1, 8'h05, 32'h22222222, 32'h0, 1'b1, 16'h0000);
      apb(1'b0, 8'h40, 32'h0, 32'h0, 1'b1, 16'h0000);
      idle(1);
      check("a_reg_out_after_errors", reg_out_m, exp_regs);

      // Back-to-back writes over all 16 registers, then back-to-back readback.
      for (int i = 0; i < 16; i++) begin
         apb(1'b1, 8'(i * 4), vec(i), 32'h0, 1'b0, 16'(1 << i));
         exp_regs[i*32 +: 32] = vec(i);
      end
      for (int i = 0; i < 16; i++) apb(1'b0, 8'(i * 4), 32'h0, vec(i), 1'b0, 16'h0000);
      idle(1);
      check("a_reg_out_all", reg_out_m, exp_regs);

      // Two wait states with read-only slot 0.
      sel = 1;
      apb(1'b1, 8'h08, 32'h12345678, 32'h0, 1'b0, 16'h0004);
      apb(1'b0, 8'h08, 32'h0, 32'h12345678, 1'b0, 16'h0000);
      apb(1'b0, 8'h00, 32'h0, 32'hCAFE0001, 1'b0, 16'h0000);
      apb(1'b1, 8'h00, 32'hFFFFFFFF, 32'h0, 1'b1, 16'h0000);
      idle(1);
      exp_regs = '0;
      exp_regs[95:64] = 32'h12345678;
      check("b_reg_out", reg_out_m, exp_regs);

      // Three wait states: reset in the second ENABLE cycle of a write aborts it.
      sel = 2;
      psel    = 1'b1;
      penable = 1'b0;
      paddr   = 8'h0C;
      pwrite  = 1'b1;
      pwdata  = 32'hAAAA5555;
      @(posedge PCLK); #1;
      penable = 1'b1;
      @(posedge PCLK); #1;
      rstn_c = 1'b0;
      #1;
      check("c_abort_pready",   pready_d[2],   0);
      check("c_abort_pslverr",  pslverr_d[2],  0);
      check("c_abort_prdata",   prdata_d[2],   0);
      check("c_abort_reg_out",  reg_out_d[2],  0);
      check("c_abort_wr_pulse", wr_pulse_d[2], 0);
      psel    = 1'b0;
      penable = 1'b0;
      @(posedge PCLK); #1;
      rstn_c = 1'b1;
      idle(1);
      check("c_reg3_after_abort", reg_out_m, 0);
      apb(1'b1, 8'h0C, 32'h5A5A5A5A, 32'h0, 1'b0, 16'h0008);
      apb(1'b0, 8'h0C, 32'h0, 32'h5A5A5A5A, 1'b0, 16'h0000);
      idle(2);
      exp_regs = '0;
      exp_regs[127:96] = 32'h5A5A5A5A;
      check("c_reg_out", reg_out_m, exp_regs);

      check("scoreboard_empty", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
